// File: rtl/csa42_pkg.sv
// csa42_pkg: shared types and helpers for the carry-save accumulator.
// Holds the FSM state enum and the operand extension function.
package csa42_pkg;

  localparam int XW = 64;

  typedef enum logic [1:0] {
    ACCUM,
    RESOLVE,
    OUT
  } state_t;

  // v holds a w-bit operand, zero-padded to XW.
  function automatic logic [XW-1:0] ext_op(
    input logic [XW-1:0] v,
    input int            w,
    input bit            sgn
  );
    logic [XW-1:0] r;
    r = v;
    for (int i = 0; i < XW; i++) begin
      if (i >= w) r[i] = sgn & v[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/csa42_accumulator_if.sv
// csa42_accumulator_if: operand beat port and result port.
// master = upstream/downstream side, slave = accumulator.
interface csa42_accumulator_if #(
  parameter int W     = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_result;
  logic [CNT_W-1:0] out_count;
  logic             out_forced;

  modport master (
    output in_valid, in_a, in_b, in_last,
    output out_ready,
    input  in_ready,
    input  out_valid, out_result,
    input  out_count, out_forced
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last,
    input  out_ready,
    output in_ready,
    output out_valid, out_result,
    output out_count, out_forced
  );
endinterface

// File: rtl/compressor42_row.sv
// compressor42_row: N combinational 4:2 cells.
// Ports: x1..x4 operands, s sum vector, carry vector (weight 2).
module compressor42_row #(
  parameter int N = 16
) (
  input  logic [N-1:0] x1,
  input  logic [N-1:0] x2,
  input  logic [N-1:0] x3,
  input  logic [N-1:0] x4,
  output logic [N-1:0] s,
  output logic [N-1:0] carry
);

  logic [N-1:0] cin;

  assign cin[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_cell
    logic ws0;
    logic w2;
    assign ws0      = x1[i] ^ x2[i];
    assign w2       = ws0 ^ x3[i] ^ x4[i];
    assign s[i]     = w2 ^ cin[i];
    assign carry[i] = w2 ? cin[i] : x4[i];
    // cout is cin-independent; MSB cout is dropped.
    if (i < N-1) begin : g_cout
      assign cin[i+1] = ws0 ? x3[i] : x1[i];
    end
  end

endmodule

// File: rtl/csa42_accumulator.sv
// csa42_accumulator: carry-save multi-operand frame accumulator.
// Ports: clk, rst (async high), bus (beats in, frame total out).
module csa42_accumulator
  import csa42_pkg::*;
#(
  parameter int W         = 8,
  parameter int ACC_W     = 16,
  parameter int MAX_BEATS = 8,
  parameter int SIGNED    = 0,
  parameter int CNT_W     = $clog2(MAX_BEATS+1)
) (
  input logic                clk,
  input logic                rst,
  csa42_accumulator_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] acc_carry;
  logic [CNT_W-1:0] count;
  logic             forced_q;
  logic [ACC_W-1:0] ext_a;
  logic [ACC_W-1:0] ext_b;
  logic [ACC_W-1:0] row_s;
  logic [ACC_W-1:0] row_c;
  logic             accept;
  logic             hit;
  logic             close;
  logic             done;

  assign ext_a = ACC_W'(ext_op(
    {{(XW-W){1'b0}}, bus.in_a}, W, SIGNED != 0));
  assign ext_b = ACC_W'(ext_op(
    {{(XW-W){1'b0}}, bus.in_b}, W, SIGNED != 0));

  compressor42_row #(.N(ACC_W)) u_row (
    .x1    (acc_sum),
    .x2    (acc_carry),
    .x3    (ext_a),
    .x4    (ext_b),
    .s     (row_s),
    .carry (row_c)
  );

  assign bus.in_ready  = (state == ACCUM) && !rst;
  assign bus.out_valid = (state == OUT);

  assign accept = bus.in_valid && bus.in_ready;
  assign hit    = (count == CNT_W'(MAX_BEATS-1));
  assign close  = accept && (bus.in_last || hit);
  assign done   = (state == OUT) && bus.out_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACCUM:   if (close) state_nxt = RESOLVE;
      RESOLVE: state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ACCUM;
      acc_sum        <= '0;
      acc_carry      <= '0;
      count          <= '0;
      forced_q       <= 1'b0;
      bus.out_result <= '0;
      bus.out_count  <= '0;
      bus.out_forced <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc_sum   <= row_s;
        acc_carry <= row_c << 1;
        count     <= count + CNT_W'(1);
      end
      if (close) forced_q <= !bus.in_last;
      if (state == RESOLVE) begin
        bus.out_result <= acc_sum + acc_carry;
        bus.out_count  <= count;
        bus.out_forced <= forced_q;
      end
      if (done) begin
        acc_sum   <= '0;
        acc_carry <= '0;
        count     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_csa42_accumulator.sv
// tb_csa42_accumulator: random + directed bench for both
// unsigned and signed builds, against an integer-sum model.
module tb_csa42_accumulator;

  localparam int W  = 8;
  localparam int AW = 16;
  localparam int MB = 8;
  localparam int CW = $clog2(MB+1);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  csa42_accumulator_if #(.W(W), .ACC_W(AW), .CNT_W(CW)) ifu ();
  csa42_accumulator_if #(.W(W), .ACC_W(AW), .CNT_W(CW)) ifs ();

  csa42_accumulator #(
    .W(W), .ACC_W(AW), .MAX_BEATS(MB), .SIGNED(0)
  ) dut_u (
    .clk (clk),
    .rst (rst),
    .bus (ifu.slave)
  );

  csa42_accumulator #(
    .W(W), .ACC_W(AW), .MAX_BEATS(MB), .SIGNED(1)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (ifs.slave)
  );

  typedef struct {
    int ru;
    int rs;
    int cnt;
    bit forced;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   sum_u  = 0;
  int   sum_s  = 0;
  int   m_cnt  = 0;
  bit   closed = 0;

  task automatic chk(string tag, longint got, longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, got, exp);
  endtask

  task automatic drive(bit v, logic [W-1:0] a,
                       logic [W-1:0] b, bit last);
    ifu.in_valid = v; ifs.in_valid = v;
    ifu.in_a = a;     ifs.in_a = a;
    ifu.in_b = b;     ifs.in_b = b;
    ifu.in_last = last; ifs.in_last = last;
  endtask

  task automatic set_ready(bit r);
    ifu.out_ready = r;
    ifs.out_ready = r;
  endtask

  task automatic model_clear();
    sum_u = 0;
    sum_s = 0;
    m_cnt = 0;
  endtask

  task automatic beat(logic [W-1:0] a, logic [W-1:0] b,
                      bit last);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    drive(1, a, b, last);
    while (!(ifu.in_ready && ifs.in_ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      chk("beat_timeout", 0, 1);
      drive(0, 0, 0, 0);
      return;
    end
    @(posedge clk);
    sum_u = (sum_u + int'(a) + int'(b)) & 'hFFFF;
    sum_s = (sum_s + int'($signed(a)) + int'($signed(b)))
            & 'hFFFF;
    m_cnt++;
    if (last || m_cnt == MB) begin
      e.ru = sum_u;
      e.rs = sum_s;
      e.cnt = m_cnt;
      e.forced = !last;
      q.push_back(e);
      model_clear();
      closed = 1;
    end
    #1 drive(0, 0, 0, 0);
  endtask

  task automatic get_result(int hold, output int lat);
    exp_t e;
    int t;
    t = 0;
    lat = -1;
    @(negedge clk);
    while (!ifu.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      chk("out_timeout", 0, 1);
      return;
    end
    lat = t;
    if (q.size() == 0) begin
      chk("unexpected_out", 0, 1);
      return;
    end
    e = q.pop_front();
    for (int h = 0; h <= hold; h++) begin
      chk("res_u", ifu.out_result, e.ru);
      chk("res_s", ifs.out_result, e.rs);
      chk("cnt_u", ifu.out_count, e.cnt);
      chk("cnt_s", ifs.out_count, e.cnt);
      chk("forced", ifu.out_forced, e.forced);
      chk("valid_s", ifs.out_valid, 1);
      chk("rdy_out", ifu.in_ready | ifs.in_ready, 0);
      if (h < hold) @(negedge clk);
    end
    set_ready(1);
    @(posedge clk);
    #1;
    set_ready(0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("valid_drop", ifu.out_valid | ifs.out_valid, 0);
    chk("rdy_back", ifu.in_ready & ifs.in_ready, 1);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    drive(0, 0, 0, 0);
    set_ready(0);
    repeat (2) @(negedge clk);
    chk("rst_valid", ifu.out_valid | ifs.out_valid, 0);
    chk("rst_ready", ifu.in_ready | ifs.in_ready, 0);
    chk("rst_res", ifu.out_result | ifs.out_result, 0);
    chk("rst_cnt", ifu.out_count, 0);
    chk("rst_forced", ifu.out_forced, 0);
    rst = 1'b0;

    // single beat, latency 2 cycles
    beat(8'd3, 8'd5, 1);
    @(negedge clk);
    chk("resolve_valid", ifu.out_valid, 0);
    chk("resolve_ready", ifu.in_ready, 0);
    get_result(0, lat);
    chk("latency", lat, 0);

    // four max beats
    for (int i = 0; i < 4; i++) beat(8'hFF, 8'hFF, i == 3);
    get_result(0, lat);

    // signed/unsigned mix
    beat(8'hFF, 8'hFE, 0);
    beat(8'h01, 8'h00, 1);
    get_result(1, lat);

    // forced flush, 9th beat held off, slow sink
    for (int i = 0; i < MB; i++) beat(8'hFF, 8'hFF, 0);
    @(negedge clk);
    drive(1, 8'hFF, 8'hFF, 0);
    chk("ninth_blocked", ifu.in_ready, 0);
    get_result(5, lat);
    beat(8'h01, 8'h00, 1);
    get_result(0, lat);

    // async reset mid-frame
    for (int i = 0; i < 3; i++) beat(8'h10, 8'h10, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", ifu.out_valid, 0);
    chk("mid_rst_ready", ifu.in_ready | ifs.in_ready, 0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    beat(8'h02, 8'h02, 1);
    get_result(0, lat);

    // async reset while result pending
    beat(8'h05, 8'h05, 1);
    repeat (2) @(negedge clk);
    chk("pend_valid", ifu.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("out_rst_valid", ifu.out_valid | ifs.out_valid, 0);
    void'(q.pop_front());
    model_clear();
    @(negedge clk);
    rst = 1'b0;

    // random frames
    for (int f = 0; f < 25; f++) begin
      closed = 0;
      while (!closed)
        beat(W'($urandom), W'($urandom),
             $urandom_range(0, 3) == 0);
      get_result($urandom_range(0, 3), lat);
    end

    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
